// File: rtl/seed_bank_streamer.sv
// Streams a captured bank of Q8.8 latent samples over a valid/ready port
// and checks every accepted sample against the 16-bit LFSR reference sequence.
module seed_bank_streamer #(
    parameter int SEED_COUNT = 64,
    parameter int DATA_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             load,
    input  logic [DATA_WIDTH*SEED_COUNT-1:0] seed_flat,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_last,
    output logic                             busy,
    output logic                             done,
    output logic                             check_error,
    output logic [7:0]                       error_count
);

    localparam int               IDX_W     = (SEED_COUNT > 1) ? $clog2(SEED_COUNT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SEED_COUNT - 1);
    localparam logic [15:0]      LFSR_SEED = 16'hACE1;

    typedef enum logic {
        ST_IDLE,
        ST_STREAM
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_bank [SEED_COUNT];
    logic [IDX_W-1:0]      r_idx;
    logic [15:0]           r_exp;
    logic                  r_done;
    logic                  r_err;
    logic [7:0]            r_err_cnt;

    logic                  w_streaming;
    logic                  w_hs;
    logic                  w_at_last;
    logic                  w_mismatch;
    logic [DATA_WIDTH-1:0] w_sample;
    logic [15:0]           w_exp_next;

    assign w_streaming = (r_state == ST_STREAM);
    assign w_sample    = r_bank[r_idx];
    assign w_at_last   = (r_idx == LAST_IDX);
    assign w_hs        = w_streaming && out_ready;
    assign w_mismatch  = (w_sample != r_exp);
    assign w_exp_next  = {r_exp[14:0], r_exp[15] ^ r_exp[13] ^ r_exp[12] ^ r_exp[10]};

    assign out_valid   = w_streaming;
    assign busy        = w_streaming;
    assign out_data    = w_streaming ? w_sample : '0;
    assign out_last    = w_streaming && w_at_last;
    assign done        = r_done;
    assign check_error = r_err;
    assign error_count = r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_exp     <= LFSR_SEED;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
            for (int unsigned k = 0; k < SEED_COUNT; k++) begin
                r_bank[k] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (load) begin
                        for (int unsigned k = 0; k < SEED_COUNT; k++) begin
                            r_bank[k] <= seed_flat[k*DATA_WIDTH +: DATA_WIDTH];
                        end
                        r_idx     <= '0;
                        r_exp     <= LFSR_SEED;
                        r_err     <= 1'b0;
                        r_err_cnt <= '0;
                        r_state   <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_hs) begin
                        r_exp <= w_exp_next;
                        if (w_mismatch) begin
                            r_err <= 1'b1;
                            if (r_err_cnt != 8'hFF) begin
                                r_err_cnt <= r_err_cnt + 8'd1;
                            end
                        end
                        // Final beat: done pulses while the block is already idle again.
                        if (w_at_last) begin
                            r_idx   <= '0;
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/seed_bank_streamer.md
SEED_BANK_STREAMER -- requirements
Module: seed_bank_streamer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter SEED_COUNT, default 64: number of latent samples in the bank.
REQ-003 Parameter DATA_WIDTH, default 16: Q8.8 sample width; SHALL be 16, since sequence checking uses a 16-bit LFSR.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 load  input  1  single-cycle pulse; captures seed_flat when idle.
REQ-007 seed_flat  input  DATA_WIDTH*SEED_COUNT  sample bank; sample k occupies bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH].
REQ-008 out_data  output  DATA_WIDTH  current sample.
REQ-009 out_valid  output  1  out_data is valid.
REQ-010 out_ready  input  1  consumer accepts out_data.
REQ-011 out_last  output  1  current sample is sample SEED_COUNT-1.
REQ-012 busy  output  1  streaming in progress.
REQ-013 done  output  1  one-cycle pulse after the final sample is accepted.
REQ-014 check_error  output  1  sticky flag: an accepted sample did not match the expected LFSR sequence.
REQ-015 error_count  output  8  number of mismatched accepted samples; saturates at 255.

Function
REQ-016 States: IDLE and STREAM; busy SHALL be 1 exactly while in STREAM.
REQ-017 IDLE with load=1 at a rising edge SHALL do all of the following:
- register all of seed_flat into an internal bank;
- set the index to 0 and the expected LFSR value to 16'hACE1;
- clear check_error and error_count;
- enter STREAM, so out_valid is 1 in the following cycle.
REQ-018 load SHALL be ignored while in STREAM; the bank SHALL NOT change mid-stream.
REQ-019 In STREAM, out_valid SHALL be 1 and out_data SHALL equal bank sample[index].
REQ-020 out_last SHALL equal out_valid AND (index == SEED_COUNT-1).
REQ-021 A handshake SHALL occur on a rising edge with out_valid=1 and out_ready=1; without a handshake, out_data, out_last and index SHALL hold.
REQ-022 On each handshake, a mismatch between out_data and the expected LFSR value SHALL set check_error and increment error_count (saturating at 255).
REQ-023 On each handshake, the expected value SHALL advance to {exp[14:0], exp[15]^exp[13]^exp[12]^exp[10]}.
REQ-024 On a handshake with index < SEED_COUNT-1, index SHALL increment by 1, giving a throughput of one sample per cycle when out_ready is held at 1.
REQ-025 On a handshake with index == SEED_COUNT-1, the block SHALL do all of the following:
- return to IDLE;
- drive out_valid and out_last to 0 in the next cycle;
- pulse done for exactly that one cycle.
REQ-026 A load in the same cycle as done is asserted SHALL be accepted, since the block is then in IDLE.
REQ-027 out_ready SHALL be ignored in IDLE.
REQ-028 check_error and error_count SHALL hold their values in IDLE until the next accepted load.
REQ-029 Index width SHALL be ceil(log2(SEED_COUNT)) bits, minimum 1.
REQ-030 SEED_COUNT=1 SHALL work: the first handshake is also the last.

Reset
REQ-031 rst_n=0 SHALL immediately, without a clock, force the following:
- state to IDLE, index to 0, bank to 0, expected LFSR to 16'hACE1;
- out_data, out_valid, out_last, busy, done, check_error and error_count to 0.
REQ-032 Reset asserted mid-stream SHALL abandon the stream, with no done pulse; the first load after reset SHALL restart from sample 0.

Verification
REQ-033 Golden bank (sample0=16'hACE1, sample1=16'h59C3, ...), load pulse, out_ready=1 -> the bench SHALL check:
- 64 consecutive valid beats in order, starting one cycle after load;
- out_last on beat 63 only;
- done for one cycle after beat 63;
- check_error=0 and error_count=0.
REQ-034 Golden bank with out_ready toggled pseudo-randomly -> out_data stable while stalled, no sample dropped or duplicated, done after exactly 64 handshakes.
REQ-035 Golden bank with bit 0 flipped in sample 5 -> check_error rises at the beat-5 handshake, error_count=1, all 64 beats still delivered.
REQ-036 Second load pulse during STREAM carrying a different seed_flat -> ignored, original data delivered; a load after done with a golden bank restarts the stream and clears check_error and error_count.
REQ-037 rst_n pulsed low at beat 10 -> outputs zero with no clock edge and no done pulse; the next load streams from sample 0 (16'hACE1).
REQ-038 SEED_COUNT=4 with an all-zero bank -> 4 beats, out_last on beat 3, error_count=4.
